// File: rtl/branch_resolve_pkg.sv
// Shared definitions: register width, comparator op codes, and the branch-resolve
// state/entry types.
package reg_defines;
   localparam int REG_W_END = 31;
endpackage

package com_defines;
   localparam int COM_OP_END = 2;
   // Conditional codes follow the RISC-V funct3 layout; the two unused slots carry always/never.
   localparam logic [COM_OP_END:0] COM_OP_EQ   = 3'd0;
   localparam logic [COM_OP_END:0] COM_OP_NE   = 3'd1;
   localparam logic [COM_OP_END:0] COM_OP_ONE  = 3'd2;
   localparam logic [COM_OP_END:0] COM_OP_ZERO = 3'd3;
   localparam logic [COM_OP_END:0] COM_OP_LT   = 3'd4;
   localparam logic [COM_OP_END:0] COM_OP_GE   = 3'd5;
   localparam logic [COM_OP_END:0] COM_OP_LTU  = 3'd6;
   localparam logic [COM_OP_END:0] COM_OP_GEU  = 3'd7;
endpackage

package branch_defines;
   typedef enum logic [1:0] {BR_IDLE, BR_EVAL, BR_REDIR} br_state_e;

   typedef struct packed {
      logic [com_defines::COM_OP_END:0] op;
      logic [reg_defines::REG_W_END:0]  lhs;
      logic [reg_defines::REG_W_END:0]  rhs;
      logic [reg_defines::REG_W_END:0]  pc;
      logic [reg_defines::REG_W_END:0]  imm;
      logic                             is_jalr;
      logic                             pred_taken;
   } br_entry_t;

   localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/branch_resolve_com.sv
// Branch condition comparator: evaluates one COM_OP_* condition on two register values.
module com
   import reg_defines::*;
   import com_defines::*;
(
   input  logic [COM_OP_END:0] i_op,
   input  logic [REG_W_END:0]  i_lhs,
   input  logic [REG_W_END:0]  i_rhs,
   output logic                o_res
);

   always_comb begin
      o_res = 1'b0;
      case (i_op)
         COM_OP_EQ:   o_res = (i_lhs == i_rhs);
         COM_OP_NE:   o_res = (i_lhs != i_rhs);
         COM_OP_ONE:  o_res = 1'b1;
         COM_OP_ZERO: o_res = 1'b0;
         COM_OP_LT:   o_res = ($signed(i_lhs) <  $signed(i_rhs));
         COM_OP_GE:   o_res = ($signed(i_lhs) >= $signed(i_rhs));
         COM_OP_LTU:  o_res = (i_lhs <  i_rhs);
         COM_OP_GEU:  o_res = (i_lhs >= i_rhs);
         default:     o_res = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: one registered entry, condition from com, mispredict
// redirect to fetch with a held request, per-branch resolve pulse and saturating counters.
module branch_resolve
   import reg_defines::*;
   import com_defines::*;
   import branch_defines::*;
#(
   parameter int CNT_W = 32
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [COM_OP_END:0]  in_op,
   input  logic [REG_W_END:0]   in_lhs,
   input  logic [REG_W_END:0]   in_rhs,
   input  logic [REG_W_END:0]   in_pc,
   input  logic [REG_W_END:0]   in_imm,
   input  logic                 in_is_jalr,
   input  logic                 in_pred_taken,
   output logic                 redir_valid,
   input  logic                 redir_ready,
   output logic [REG_W_END:0]   redir_pc,
   output logic                 res_valid,
   output logic                 res_taken,
   output logic                 res_mispred,
   output logic [CNT_W-1:0]     branch_cnt,
   output logic [CNT_W-1:0]     mispred_cnt
);

   localparam logic [REG_W_END:0] ALIGN_MASK = {{REG_W_END{1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

   br_state_e          r_state;
   br_entry_t          r_entry;
   logic [REG_W_END:0] r_redir_pc;
   logic               r_res_valid;
   logic               r_res_taken;
   logic               r_res_mispred;
   logic [CNT_W-1:0]   r_branch_cnt;
   logic [CNT_W-1:0]   r_mispred_cnt;

   logic               w_taken;
   logic [REG_W_END:0] w_target;
   logic [REG_W_END:0] w_next;
   logic               w_mispred;
   logic               w_accept;
   br_entry_t          w_entry_in;

   com u_com (
      .i_op  (r_entry.op),
      .i_lhs (r_entry.lhs),
      .i_rhs (r_entry.rhs),
      .o_res (w_taken)
   );

   assign w_target  = r_entry.is_jalr ? ((r_entry.lhs + r_entry.imm) & ALIGN_MASK)
                                      : (r_entry.pc + r_entry.imm);
   assign w_next    = w_taken ? w_target : (r_entry.pc + (REG_W_END+1)'(INSTR_BYTES));
   // A taken JALR always redirects: the front end only ever predicts pc+imm.
   assign w_mispred = (w_taken != r_entry.pred_taken) || (r_entry.is_jalr && w_taken);

   assign in_ready  = !flush && ((r_state == BR_IDLE) || ((r_state == BR_EVAL) && !w_mispred));
   assign w_accept  = in_valid && in_ready;

   assign w_entry_in.op         = in_op;
   assign w_entry_in.lhs        = in_lhs;
   assign w_entry_in.rhs        = in_rhs;
   assign w_entry_in.pc         = in_pc;
   assign w_entry_in.imm        = in_imm;
   assign w_entry_in.is_jalr    = in_is_jalr;
   assign w_entry_in.pred_taken = in_pred_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= BR_IDLE;
         r_entry       <= '0;
         r_redir_pc    <= '0;
         r_res_valid   <= 1'b0;
         r_res_taken   <= 1'b0;
         r_res_mispred <= 1'b0;
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else if (flush) begin
         r_state     <= BR_IDLE;
         r_res_valid <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         case (r_state)
            BR_IDLE: begin
               if (w_accept) begin
                  r_entry <= w_entry_in;
                  r_state <= BR_EVAL;
               end
            end
            BR_EVAL: begin
               r_res_valid   <= 1'b1;
               r_res_taken   <= w_taken;
               r_res_mispred <= w_mispred;
               if (r_branch_cnt != CNT_MAX)
                  r_branch_cnt <= r_branch_cnt + CNT_W'(1);
               if (w_mispred) begin
                  if (r_mispred_cnt != CNT_MAX)
                     r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
                  r_redir_pc <= w_next;
                  r_state    <= BR_REDIR;
               end else if (w_accept) begin
                  r_entry <= w_entry_in;
               end else begin
                  r_state <= BR_IDLE;
               end
            end
            BR_REDIR: begin
               if (redir_ready)
                  r_state <= BR_IDLE;
            end
            default: r_state <= BR_IDLE;
         endcase
      end
   end

   assign redir_valid = (r_state == BR_REDIR);
   assign redir_pc    = r_redir_pc;
   assign res_valid   = r_res_valid;
   assign res_taken   = r_res_taken;
   assign res_mispred = r_res_mispred;
   assign branch_cnt  = r_branch_cnt;
   assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: transaction-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic. A CNT_W=2 twin checks saturation.
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [2:0]  in_op;
   logic [31:0] in_lhs, in_rhs, in_pc, in_imm;
   logic        in_is_jalr, in_pred_taken;
   logic        redir_ready;

   logic        in_ready, redir_valid, res_valid, res_taken, res_mispred;
   logic [31:0] redir_pc, branch_cnt, mispred_cnt;
   logic        in_ready_s, redir_valid_s, res_valid_s, res_taken_s, res_mispred_s;
   logic [31:0] redir_pc_s;
   logic [1:0]  branch_cnt_s, mispred_cnt_s;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state: what is in flight, what fetch should see, how many have resolved
   bit          m_busy, m_redir, m_resv, m_rest, m_resm;
   logic [31:0] m_rpc;
   logic [2:0]  e_op;
   logic [31:0] e_lhs, e_rhs, e_pc, e_imm;
   bit          e_jalr, e_pred;
   int          m_bc, m_mc;

   always #5 clk = ~clk;

   branch_resolve #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_lhs(in_lhs), .in_rhs(in_rhs), .in_pc(in_pc), .in_imm(in_imm),
      .in_is_jalr(in_is_jalr), .in_pred_taken(in_pred_taken), .redir_valid(redir_valid),
      .redir_ready(redir_ready), .redir_pc(redir_pc), .res_valid(res_valid), .res_taken(res_taken),
      .res_mispred(res_mispred), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   branch_resolve #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_op(in_op), .in_lhs(in_lhs), .in_rhs(in_rhs), .in_pc(in_pc), .in_imm(in_imm),
      .in_is_jalr(in_is_jalr), .in_pred_taken(in_pred_taken), .redir_valid(redir_valid_s),
      .redir_ready(redir_ready), .redir_pc(redir_pc_s), .res_valid(res_valid_s), .res_taken(res_taken_s),
      .res_mispred(res_mispred_s), .branch_cnt(branch_cnt_s), .mispred_cnt(mispred_cnt_s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit f_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd2: return 1'b1;
         3'd3: return 1'b0;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         default: return a >= b;
      endcase
   endfunction

   function automatic bit f_mis();
      bit t;
      t = f_taken(e_op, e_lhs, e_rhs);
      return (t != e_pred) || (e_jalr && t);
   endfunction

   function automatic logic [31:0] f_next();
      logic [31:0] tgt;
      tgt = e_jalr ? ((e_lhs + e_imm) & 32'hFFFF_FFFE) : (e_pc + e_imm);
      return f_taken(e_op, e_lhs, e_rhs) ? tgt : (e_pc + 32'd4);
   endfunction

   function automatic bit f_ready();
      return !flush && !m_redir && (!m_busy || !f_mis());
   endfunction

   function automatic logic [31:0] sat2(input int v);
      return (v > 3) ? 32'd3 : 32'(v);
   endfunction

   task automatic model_reset();
      m_busy = 0; m_redir = 0; m_resv = 0; m_rest = 0; m_resm = 0;
      m_rpc = '0; m_bc = 0; m_mc = 0;
   endtask

   task automatic model_latch();
      m_busy = 1; e_op = in_op; e_lhs = in_lhs; e_rhs = in_rhs;
      e_pc = in_pc; e_imm = in_imm; e_jalr = in_is_jalr; e_pred = in_pred_taken;
   endtask

   // advance one clock; the model consumes the inputs that were present at the edge
   task automatic step();
      bit rdy;
      @(posedge clk);
      #1;
      rdy = f_ready();
      if (flush) begin
         m_busy = 0; m_redir = 0; m_resv = 0;
      end else if (m_redir) begin
         m_resv = 0;
         if (redir_ready) m_redir = 0;
      end else if (m_busy) begin
         m_resv = 1;
         m_rest = f_taken(e_op, e_lhs, e_rhs);
         m_resm = f_mis();
         m_bc++;
         if (m_resm) begin
            m_mc++;
            m_rpc   = f_next();
            m_redir = 1;
            m_busy  = 0;
         end else if (in_valid && rdy) begin
            model_latch();
         end else begin
            m_busy = 0;
         end
      end else begin
         m_resv = 0;
         if (in_valid && rdy) model_latch();
      end
   endtask

   // compare process: every falling edge, all visible outputs of both instances against the model
   always @(negedge clk) begin
      chk("redir_valid", {31'b0, redir_valid}, {31'b0, m_redir});
      if (m_redir) chk("redir_pc", redir_pc, m_rpc);
      chk("res_valid", {31'b0, res_valid}, {31'b0, m_resv});
      if (m_resv) begin
         chk("res_taken", {31'b0, res_taken}, {31'b0, m_rest});
         chk("res_mispred", {31'b0, res_mispred}, {31'b0, m_resm});
      end
      chk("in_ready", {31'b0, in_ready}, {31'b0, f_ready()});
      chk("branch_cnt", branch_cnt, 32'(m_bc));
      chk("mispred_cnt", mispred_cnt, 32'(m_mc));
      chk("branch_cnt_w2", {30'b0, branch_cnt_s}, sat2(m_bc));
      chk("mispred_cnt_w2", {30'b0, mispred_cnt_s}, sat2(m_mc));
      chk("redir_valid_w2", {31'b0, redir_valid_s}, {31'b0, m_redir});
   end

   task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input bit jalr, input bit pred);
      in_valid = 1; in_op = op; in_lhs = a; in_rhs = b; in_pc = pc; in_imm = imm;
      in_is_jalr = jalr; in_pred_taken = pred;
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0; flush = 0; in_valid = 0; in_op = '0; in_lhs = '0; in_rhs = '0;
      in_pc = '0; in_imm = '0; in_is_jalr = 0; in_pred_taken = 0; redir_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst redir_valid", {31'b0, redir_valid}, 32'd0);
      chk("rst res_valid", {31'b0, res_valid}, 32'd0);
      chk("rst redir_pc", redir_pc, 32'd0);
      chk("rst branch_cnt", branch_cnt, 32'd0);
      chk("rst mispred_cnt", mispred_cnt, 32'd0);
      rst_n = 1;

      // BEQ taken, predicted not taken
      do_reset();
      redir_ready = 0;
      offer(3'd0, 5, 5, 32'h100, 32'h20, 0, 0);
      step(); in_valid = 0; step(); #1;
      chk("beq res_taken", {31'b0, res_taken}, 32'd1);
      chk("beq res_mispred", {31'b0, res_mispred}, 32'd1);
      chk("beq redir_pc", redir_pc, 32'h120);
      chk("beq mispred_cnt", mispred_cnt, 32'd1);
      redir_ready = 1; step(); #1;
      chk("beq redir drop", {31'b0, redir_valid}, 32'd0);
      $display("[TB] BEQ mispredict redirect done");

      // BNE not taken, correctly predicted
      do_reset();
      offer(3'd1, 5, 5, 32'h200, 32'h40, 0, 0);
      step(); in_valid = 0; step(); #1;
      chk("bne res_valid", {31'b0, res_valid}, 32'd1);
      chk("bne res_taken", {31'b0, res_taken}, 32'd0);
      chk("bne redir_valid", {31'b0, redir_valid}, 32'd0);
      chk("bne in_ready", {31'b0, in_ready}, 32'd1);
      chk("bne branch_cnt", branch_cnt, 32'd1);
      $display("[TB] BNE correct prediction done");

      // BLT signed then BLTU unsigned, back to back
      do_reset();
      offer(3'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h10, 0, 1);
      step();
      offer(3'd6, 32'hFFFF_FFFF, 1, 32'h304, 32'h10, 0, 0);
      step(); #1;
      chk("blt res_taken", {31'b0, res_taken}, 32'd1);
      chk("blt res_mispred", {31'b0, res_mispred}, 32'd0);
      in_valid = 0; step(); #1;
      chk("bltu res_valid", {31'b0, res_valid}, 32'd1);
      chk("bltu res_taken", {31'b0, res_taken}, 32'd0);
      chk("bltu branch_cnt", branch_cnt, 32'd2);
      redir_ready = 0;
      offer(3'd0, 1, 2, 32'hFFFF_FFFC, 32'h8, 0, 1);
      step(); in_valid = 0; step(); #1;
      chk("wrap redir_valid", {31'b0, redir_valid}, 32'd1);
      chk("wrap redir_pc", redir_pc, 32'h0);
      redir_ready = 1; step();
      $display("[TB] BLT/BLTU/PC wrap done");

      // JALR with fetch stalling the redirect
      do_reset();
      redir_ready = 0;
      offer(3'd2, 32'h1001, 0, 32'h400, 32'h2, 1, 1);
      step();
      offer(3'd0, 0, 0, 32'h500, 32'h4, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("jalr redir_valid", {31'b0, redir_valid}, 32'd1);
         chk("jalr redir_pc", redir_pc, 32'h1002);
         chk("jalr in_ready", {31'b0, in_ready}, 32'd0);
         step();
      end
      redir_ready = 1; step(); #1;
      chk("jalr redir done", {31'b0, redir_valid}, 32'd0);
      in_valid = 0; step(); step();
      $display("[TB] JALR held redirect done");

      // flush in REDIR, in EVAL, and with in_valid
      do_reset();
      redir_ready = 0;
      offer(3'd0, 7, 7, 32'h600, 32'h8, 0, 0);
      step(); in_valid = 0; step();
      flush = 1; step(); flush = 0; #1;
      chk("flush redir_valid", {31'b0, redir_valid}, 32'd0);
      chk("flush mispred_cnt", mispred_cnt, 32'd1);
      offer(3'd1, 1, 2, 32'h700, 32'h8, 0, 1);
      step(); in_valid = 0;
      flush = 1; step(); flush = 0; #1;
      chk("flush eval res_valid", {31'b0, res_valid}, 32'd0);
      chk("flush eval branch_cnt", branch_cnt, 32'd1);
      flush = 1;
      offer(3'd1, 1, 2, 32'h800, 32'h8, 0, 1);
      #1;
      chk("flush in_ready", {31'b0, in_ready}, 32'd0);
      step(); flush = 0; in_valid = 0; step(); #1;
      chk("flush acc res_valid", {31'b0, res_valid}, 32'd0);
      chk("flush acc branch_cnt", branch_cnt, 32'd1);
      $display("[TB] flush scenarios done");

      // five back-to-back mispredicts; narrow counters saturate
      do_reset();
      redir_ready = 1;
      offer(3'd0, 3, 3, 32'h800, 32'h10, 0, 0);
      repeat (15) step();
      in_valid = 0; step(); #1;
      chk("sat mispred_cnt32", mispred_cnt, 32'd5);
      chk("sat mispred_cnt2", {30'b0, mispred_cnt_s}, 32'd3);
      chk("sat branch_cnt2", {30'b0, branch_cnt_s}, 32'd3);
      $display("[TB] counter saturation done");

      // async reset while a redirect is pending
      redir_ready = 0;
      offer(3'd0, 3, 3, 32'h900, 32'h10, 0, 0);
      step(); in_valid = 0; step(); #1;
      chk("pre-rst redir_valid", {31'b0, redir_valid}, 32'd1);
      rst_n = 0;
      #1;
      chk("async redir_valid", {31'b0, redir_valid}, 32'd0);
      chk("async redir_pc", redir_pc, 32'd0);
      chk("async res_valid", {31'b0, res_valid}, 32'd0);
      chk("async branch_cnt", branch_cnt, 32'd0);
      chk("async mispred_cnt", mispred_cnt, 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      $display("[TB] async reset mid-redirect done");

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid      = ($urandom_range(0, 9) < 7);
         flush         = ($urandom_range(0, 19) == 0);
         redir_ready   = $urandom_range(0, 1) == 1;
         in_op         = 3'($urandom_range(0, 7));
         in_lhs        = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) - 32'd3;
         in_rhs        = ($urandom_range(0, 1) == 0) ? in_lhs : 32'($urandom_range(0, 7)) - 32'd3;
         in_pc         = $urandom & 32'hFFFF_FFFC;
         in_imm        = ($urandom & 32'h1FE) - 32'h100;
         in_is_jalr    = ($urandom_range(0, 7) == 0);
         in_pred_taken = $urandom_range(0, 1) == 1;
         step();
      end
      flush = 0; in_valid = 0; redir_ready = 1;
      repeat (3) step();
      $display("[TB] random traffic done, %0d resolved, %0d mispredicted", m_bc, m_mc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
